// File: rtl/codecaudio_onchipmem_dp.sv
// Dual-port Avalon-MM on-chip RAM for CodecAudio (s1: Nios CPU, s2: audio DMA).
// Optional power-up clear sequencer: define CODECAUDIO_ONCHIPMEM_CLEAR_EN.
module codecaudio_onchipmem_dp #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int READ_LATENCY = 1,
   parameter     INIT_FILE    = "CodecAudio_onchipmem.hex"
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      reset_req,
   input  logic                      clken,
   input  logic [ADDR_WIDTH-1:0]     s1_address,
   input  logic                      s1_chipselect,
   input  logic                      s1_read,
   input  logic                      s1_write,
   input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
   input  logic [DATA_WIDTH-1:0]     s1_writedata,
   output logic [DATA_WIDTH-1:0]     s1_readdata,
   output logic                      s1_readdatavalid,
   output logic                      s1_waitrequest,
   input  logic [ADDR_WIDTH-1:0]     s2_address,
   input  logic                      s2_chipselect,
   input  logic                      s2_read,
   input  logic                      s2_write,
   input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
   input  logic [DATA_WIDTH-1:0]     s2_writedata,
   output logic [DATA_WIDTH-1:0]     s2_readdata,
   output logic                      s2_readdatavalid,
   output logic                      s2_waitrequest
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   if ((DATA_WIDTH % 8) != 0 ||
       (READ_LATENCY != 1 && READ_LATENCY != 2) ||
       $bits(INIT_FILE) == 0) begin : g_bad_cfg
      $error("codecaudio_onchipmem_dp: illegal parameters");
   end

   // Power-up contents are attached by the FPGA flow from INIT_FILE.
   (* ram_init_file = INIT_FILE *)
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic en;
   logic ready;
   logic req1, req2, coll;
   logic acc1, acc2;
   logic [1:0] rd_acc;

   assign en = clken & ~reset_req;

`ifdef CODECAUDIO_ONCHIPMEM_CLEAR_EN
   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      READY
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  clr_we;

   // Clear-sequencer state and word counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Walk every word once, writing zero, only on enabled cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      ready   = 1'b0;
      unique case (state_q)
         IDLE: begin
            state_d = CLEAR;
            cnt_d   = '0;
         end
         CLEAR: begin
            if (en) begin
               clr_we = 1'b1;
               cnt_d  = cnt_q + ADDR_WIDTH'(1);
               if (&cnt_q) state_d = READY;
            end
         end
         READY: ready = 1'b1;
         default: state_d = IDLE;
      endcase
   end
`else
   assign ready = 1'b1;
`endif

   assign req1 = s1_chipselect & (s1_read | s1_write);
   assign req2 = s2_chipselect & (s2_read | s2_write);

   // Same word, at least one writer: s1 has priority.
   assign coll = req1 & req2 & (s1_address == s2_address)
               & (s1_write | s2_write);

   assign s1_waitrequest = ~en | ~ready;
   assign s2_waitrequest = ~en | ~ready | coll;

   assign acc1 = req1 & ~s1_waitrequest;
   assign acc2 = req2 & ~s2_waitrequest;

   // read+write in one request is treated as a write.
   assign rd_acc = {acc2 & ~s2_write, acc1 & ~s1_write};

   // Byte-lane writes from both ports, plus the clear sequencer.
   always_ff @(posedge clk) begin
`ifdef CODECAUDIO_ONCHIPMEM_CLEAR_EN
      if (clr_we) mem_q[cnt_q] <= '0;
`endif
      for (int b = 0; b < NB; b++) begin
         if (acc1 && s1_write && s1_byteenable[b])
            mem_q[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
         if (acc2 && s2_write && s2_byteenable[b])
            mem_q[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
      end
   end

   logic [1:0]            v1_q;
   logic [DATA_WIDTH-1:0] d1_q [2];
   logic [1:0]            rdv;
   logic [DATA_WIDTH-1:0] rdd  [2];

   // First read stage: capture the word (pre-write value) at acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1_q    <= '0;
         d1_q[0] <= '0;
         d1_q[1] <= '0;
      end else if (en) begin
         v1_q <= rd_acc;
         if (rd_acc[0]) d1_q[0] <= mem_q[s1_address];
         if (rd_acc[1]) d1_q[1] <= mem_q[s2_address];
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic [1:0]            v2_q;
      logic [DATA_WIDTH-1:0] d2_q [2];

      // Second read stage: advance only valid data so readdata holds.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            v2_q    <= '0;
            d2_q[0] <= '0;
            d2_q[1] <= '0;
         end else if (en) begin
            v2_q <= v1_q;
            if (v1_q[0]) d2_q[0] <= d1_q[0];
            if (v1_q[1]) d2_q[1] <= d1_q[1];
         end
      end

      assign rdv    = v2_q;
      assign rdd[0] = d2_q[0];
      assign rdd[1] = d2_q[1];
   end else begin : g_lat1
      assign rdv    = v1_q;
      assign rdd[0] = d1_q[0];
      assign rdd[1] = d1_q[1];
   end

   assign s1_readdata      = rdd[0];
   assign s2_readdata      = rdd[1];
   assign s1_readdatavalid = rdv[0] & en;
   assign s2_readdatavalid = rdv[1] & en;

endmodule
